// File: rtl/sp_ram_pkg.sv
// Shared defaults and the read-data owner encoding for the shared-RAM arbiter.
package sp_ram_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_ADDR_W = 6;
  localparam int DEF_CNT_W  = 16;

  // Owner of the read data currently on the RAM output, and of the most recent grant.
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_A    = 2'd1,
    OWN_B    = 2'd2
  } owner_e;

endpackage

// File: rtl/sp_ram_core.sv
// Single-port RAM: synchronous write, registered read address, one access per cycle.
module sp_ram_core #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] raddr_reg;

  // Write port: storage is never reset, so contents survive the arbiter's reset.
  always_ff @(posedge clk) begin
    if (en && we) begin
      mem[addr] <= wdata;
    end
  end

  // Read address register loads only on a granted read; otherwise it holds.
  always_ff @(posedge clk) begin
    if (en && !we) begin
      raddr_reg <= addr;
    end
  end

  // Reading through the registered address makes a write on the previous
  // edge visible to a read granted right after it.
  assign rdata = mem[raddr_reg];

endmodule

// File: rtl/sp_ram_arbiter.sv
// Two-port round-robin (or fixed-priority) arbiter in front of one shared single-port RAM.
module sp_ram_arbiter
  import sp_ram_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int FIXED_PRIO = 0,
  parameter int CNT_W      = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_gnt,
  output logic              a_rvalid,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_gnt,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] b_rdata,
  output logic [CNT_W-1:0]  conflicts
);

  owner_e            last_gnt_reg, last_gnt_next;
  owner_e            rd_owner_reg, rd_owner_next;
  logic [CNT_W-1:0]  conflicts_reg;
  logic              a_win, b_win;
  logic              ram_en, ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata, ram_rdata;
  logic [1:0]        rvalid_vec;

  // Grant decision: a lone requester wins; on a tie the port that did not win
  // last time goes first (or A always, in fixed-priority mode). Nothing during reset.
  always_comb begin
    a_win = 1'b0;
    b_win = 1'b0;
    if (!rst) begin
      if (a_req && b_req) begin
        if (FIXED_PRIO != 0 || last_gnt_reg == OWN_B) a_win = 1'b1;
        else                                          b_win = 1'b1;
      end else begin
        a_win = a_req;
        b_win = b_req;
      end
    end
  end

  // Next values for the last-winner and read-owner registers.
  always_comb begin
    last_gnt_next = last_gnt_reg;
    rd_owner_next = OWN_NONE;
    if (a_win) begin
      last_gnt_next = OWN_A;
      if (!a_we) rd_owner_next = OWN_A;
    end else if (b_win) begin
      last_gnt_next = OWN_B;
      if (!b_we) rd_owner_next = OWN_B;
    end
  end

  // Arbitration state; last winner resets to B so A takes the first tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_gnt_reg <= OWN_B;
      rd_owner_reg <= OWN_NONE;
    end else begin
      last_gnt_reg <= last_gnt_next;
      rd_owner_reg <= rd_owner_next;
    end
  end

  // Saturating count of cycles where both ports asked at once.
  always_ff @(posedge clk) begin
    if (rst) begin
      conflicts_reg <= '0;
    end else if (a_req && b_req && conflicts_reg != '1) begin
      conflicts_reg <= conflicts_reg + CNT_W'(1);
    end
  end

  // Route the winning port's fields to the RAM; only one port can win.
  always_comb begin
    ram_en    = a_win || b_win;
    ram_we    = a_win ? a_we    : b_we;
    ram_addr  = a_win ? a_addr  : b_addr;
    ram_wdata = a_win ? a_wdata : b_wdata;
  end

  sp_ram_core #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_core (
    .clk   (clk),
    .en    (ram_en),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  // Per-port rvalid from the owner tag; forced low while reset is asserted so a
  // read granted just before reset never reports data.
  for (genvar gi = 0; gi < 2; gi++) begin : g_rvalid
    assign rvalid_vec[gi] = !rst && (rd_owner_reg == ((gi == 0) ? OWN_A : OWN_B));
  end

  assign a_gnt     = a_win;
  assign b_gnt     = b_win;
  assign a_rvalid  = rvalid_vec[0];
  assign b_rvalid  = rvalid_vec[1];
  assign a_rdata   = ram_rdata;
  assign b_rdata   = ram_rdata;
  assign conflicts = conflicts_reg;

endmodule
